imem_loader: RTL

- Writer side of the instruction-memory interface: receives a framed byte stream (UART/host bridge), assembles little-endian 32-bit words and writes them into instruction memory through a write port.
- Holds the CPU core in reset (cpu_rst) from power-up until a complete, checksum-valid image has been written, then releases it.
- Sits beside cpu_top; imem gains a write port driven by this block.

---
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write port of the image loader
// master: host bridge / memory side; slave: the loader itself.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream to instruction-memory loader, holds the CPU in reset until verified
// Frame: SYNC, LEN_LO, LEN_HI, N little-endian words, XOR checksum of payload bytes.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  imem_loader_if.slave bus,
  output logic        cpu_rst,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR} state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;
  logic [7:0]  csum;
  logic        accept;
  logic [15:0] len_next;

  assign bus.in_ready = ~rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign len_next     = {bus.in_data, len_lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= BASE_ADDR;
      bus.imem_wdata <= 32'h0;
      cpu_rst        <= 1'b1;
      done           <= 1'b0;
      err            <= 1'b0;
      words_loaded   <= 16'h0;
      len_lo         <= 8'h0;
      len            <= 16'h0;
      word_idx       <= 16'h0;
      byte_idx       <= 2'd0;
      asm_q          <= 24'h0;
      csum           <= 8'h0;
    end else begin
      bus.imem_we <= 1'b0;
      // The address advances only after the write cycle has presented it.
      if (bus.imem_we)
        bus.imem_addr <= bus.imem_addr + 32'd4;

      if (accept) begin
        case (state)
          IDLE, DONE, ERR: begin
            if (bus.in_data == SYNC_BYTE) begin
              state         <= LEN0;
              cpu_rst       <= 1'b1;
              done          <= 1'b0;
              err           <= 1'b0;
              words_loaded  <= 16'h0;
              bus.imem_addr <= BASE_ADDR;
              csum          <= 8'h0;
            end
          end
          LEN0: begin
            len_lo <= bus.in_data;
            state  <= LEN1;
          end
          LEN1: begin
            len      <= len_next;
            word_idx <= 16'h0;
            byte_idx <= 2'd0;
            if ({1'b0, len_next} > MAX_LEN) begin
              state   <= ERR;
              err     <= 1'b1;
              cpu_rst <= 1'b1;
              done    <= 1'b0;
            end else if (len_next == 16'h0) begin
              state <= CHK;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            csum     <= csum ^ bus.in_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_q[7:0]   <= bus.in_data;
              2'd1: asm_q[15:8]  <= bus.in_data;
              2'd2: asm_q[23:16] <= bus.in_data;
              default: begin
                // Write data is captured separately so the next word can start assembling now.
                bus.imem_wdata <= {bus.in_data, asm_q};
                bus.imem_we    <= 1'b1;
                words_loaded   <= words_loaded + 16'd1;
                word_idx       <= word_idx + 16'd1;
                if (word_idx + 16'd1 == len)
                  state <= CHK;
              end
            endcase
          end
          CHK: begin
            if (bus.in_data == csum) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state   <= ERR;
              err     <= 1'b1;
              cpu_rst <= 1'b1;
              done    <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
